// File: rtl/first_stage_flp_adder.sv
// rtl/first_stage_flp_adder.sv - exponent compare/difference stage of a floating-point adder
//
// Purpose: registers the larger of two biased exponents, their two's-complement
// difference (mantissa alignment amount), a swap flag, an equality flag and an
// Inf/NaN detect. One cycle of latency, no backpressure.
//
// Optional feature: define FLP_ADDER_SHIFT_SAT_EN to clamp |mant| to MAX_SHIFT
// while keeping its sign.
//
// Ports:
//   clk       in   1  rising-edge clock
//   rst       in   1  synchronous active-high reset
//   exp1      in   8  biased exponent of operand A
//   exp2      in   8  biased exponent of operand B
//   in_valid  in   1  exp1/exp2 valid this cycle
//   exp       out  9  {1'b0, max(exp1, exp2)}
//   mant      out  9  exp1 - exp2, two's complement (optionally clamped)
//   swap      out  1  exp2 > exp1
//   special   out  1  either exponent is 8'hFF
//   eq        out  1  exp1 == exp2
//   out_valid out  1  in_valid delayed by one cycle

module first_stage_flp_adder #(
  parameter int MAX_SHIFT = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] exp1,
  input  logic [7:0] exp2,
  input  logic       in_valid,
  output logic [8:0] exp,
  output logic [8:0] mant,
  output logic       swap,
  output logic       special,
  output logic       eq,
  output logic       out_valid
);

  // |exp1 - exp2| never exceeds 255, so a limit of 255 leaves mant untouched.
`ifdef FLP_ADDER_SHIFT_SAT_EN
  localparam int SAT_LIMIT = MAX_SHIFT;
`else
  localparam int SAT_LIMIT = (MAX_SHIFT > 255) ? MAX_SHIFT : 255;
`endif
  localparam int                 LIM_INT = (SAT_LIMIT > 255) ? 255 : SAT_LIMIT;
  localparam logic signed [9:0] LIM_POS = 10'(LIM_INT);
  localparam logic signed [9:0] LIM_NEG = -10'(LIM_INT);

  logic signed [9:0] diff;
  logic        [8:0] mant_next;
  logic              swap_next;
  logic              eq_next;
  logic              special_next;

  // One extra sign bit so the full -255..+255 range compares cleanly.
  assign diff         = $signed({2'b00, exp1}) - $signed({2'b00, exp2});
  assign swap_next    = (exp2 > exp1);
  assign eq_next      = (exp1 == exp2);
  assign special_next = (exp1 == 8'hFF) || (exp2 == 8'hFF);

  always_comb begin
    mant_next = diff[8:0];
    if (diff > LIM_POS) begin
      mant_next = LIM_POS[8:0];
    end else if (diff < LIM_NEG) begin
      mant_next = LIM_NEG[8:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp       <= 9'h000;
      mant      <= 9'h000;
      swap      <= 1'b0;
      eq        <= 1'b0;
      special   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        exp     <= {1'b0, (swap_next ? exp2 : exp1)};
        mant    <= mant_next;
        swap    <= swap_next;
        eq      <= eq_next;
        special <= special_next;
      end
    end
  end

endmodule

// File: tb/tb_first_stage_flp_adder.sv
// tb/tb_first_stage_flp_adder.sv - directed-vector bench for first_stage_flp_adder

module tb_first_stage_flp_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] exp1;
  logic [7:0] exp2;
  logic       in_valid;
  logic [8:0] exp;
  logic [8:0] mant;
  logic       swap;
  logic       special;
  logic       eq;
  logic       out_valid;

  int checks = 0;
  int errors = 0;

`ifdef FLP_ADDER_SHIFT_SAT_EN
  localparam logic [8:0] M_55_AA = 9'h1E7;
  localparam logic [8:0] M_FE_01 = 9'h019;
  localparam logic [8:0] M_FF_7F = 9'h019;
  localparam logic [8:0] M_FF_00 = 9'h019;
  localparam logic [8:0] M_00_FF = 9'h1E7;
`else
  localparam logic [8:0] M_55_AA = 9'h1AB;
  localparam logic [8:0] M_FE_01 = 9'h0FD;
  localparam logic [8:0] M_FF_7F = 9'h080;
  localparam logic [8:0] M_FF_00 = 9'h0FF;
  localparam logic [8:0] M_00_FF = 9'h101;
`endif

  first_stage_flp_adder dut (
    .clk       (clk),
    .rst       (rst),
    .exp1      (exp1),
    .exp2      (exp2),
    .in_valid  (in_valid),
    .exp       (exp),
    .mant      (mant),
    .swap      (swap),
    .special   (special),
    .eq        (eq),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Drive one cycle of inputs, clock it in, then check all registered outputs.
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic [8:0] e_exp, input logic [8:0] e_mant,
                      input logic e_swap, input logic e_eq, input logic e_spec,
                      input logic e_ov);
    rst      = r;
    in_valid = v;
    exp1     = a;
    exp2     = b;
    @(posedge clk);
    #1;
    check({tag, ".exp"},       32'(exp),       32'(e_exp));
    check({tag, ".mant"},      32'(mant),      32'(e_mant));
    check({tag, ".swap"},      32'(swap),      32'(e_swap));
    check({tag, ".eq"},        32'(eq),        32'(e_eq));
    check({tag, ".special"},   32'(special),   32'(e_spec));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; exp1 = 8'h00; exp2 = 8'h00;
    #2;
    //     tag        rst  v    exp1   exp2   exp     mant     swp  eq   spc  ov
    step("reset",     1, 1, 8'h55, 8'hAA, 9'h000, 9'h000,  0,   0,   0,   0);
    step("zero",      0, 1, 8'h00, 8'h00, 9'h000, 9'h000,  0,   1,   0,   1);
    step("b_larger",  0, 1, 8'h55, 8'hAA, 9'h0AA, M_55_AA, 1,   0,   0,   1);
    step("a_larger",  0, 1, 8'hFE, 8'h01, 9'h0FE, M_FE_01, 0,   0,   0,   1);
    step("special",   0, 1, 8'hFF, 8'h7F, 9'h0FF, M_FF_7F, 0,   0,   1,   1);
    step("ff_00",     0, 1, 8'hFF, 8'h00, 9'h0FF, M_FF_00, 0,   0,   1,   1);
    step("00_ff",     0, 1, 8'h00, 8'hFF, 9'h0FF, M_00_FF, 1,   0,   1,   1);
    step("tie",       0, 1, 8'h3C, 8'h3C, 9'h03C, 9'h000,  0,   1,   0,   1);
    step("hold1",     0, 0, 8'h12, 8'h34, 9'h03C, 9'h000,  0,   1,   0,   0);
    step("hold2",     0, 0, 8'hFF, 8'h00, 9'h03C, 9'h000,  0,   1,   0,   0);
    step("hold3",     0, 0, 8'h01, 8'hFE, 9'h03C, 9'h000,  0,   1,   0,   0);
    step("isolated",  0, 1, 8'h55, 8'hAA, 9'h0AA, M_55_AA, 1,   0,   0,   1);
    step("gap",       0, 0, 8'h00, 8'h00, 9'h0AA, M_55_AA, 1,   0,   0,   0);
    step("in_flight", 0, 1, 8'hFE, 8'h01, 9'h0FE, M_FE_01, 0,   0,   0,   1);
    step("rst_mid",   1, 1, 8'h10, 8'h20, 9'h000, 9'h000,  0,   0,   0,   0);
    step("post_rst",  0, 0, 8'h10, 8'h20, 9'h000, 9'h000,  0,   0,   0,   0);
    step("restart",   0, 1, 8'h20, 8'h10, 9'h020, 9'h010,  0,   0,   0,   1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
